// File: rtl/freq_meter_seq.sv
// freq_meter_seq: gate-window sequencer for the frequency meter (open, close, calc, hand off, gap).
// Auto-ranging on successful results is compiled in when FREQ_SEQ_AUTORANGE_EN is defined.
module freq_meter_seq #(
    parameter int unsigned GATE_BASE  = 25_000_000,
    parameter int unsigned GAP_CYCLES = 5_000_000,
    parameter int unsigned LO_THR     = 1_000,
    parameter int unsigned HI_THR     = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_run,
    input  logic        i_key_range,
    output logic        o_gate_soft,
    input  logic        i_gate_real,
    input  logic        i_calc_done,
    input  logic [31:0] i_cnt_x,
    output logic [1:0]  o_range,
    output logic        o_res_valid,
    input  logic        i_res_ready,
    output logic [31:0] o_res_cnt,
    output logic [1:0]  o_res_range,
    output logic        o_res_timeout,
    output logic        o_busy
);

    localparam logic [31:0] GATE_W   = 32'(GATE_BASE);
    localparam logic [31:0] TMO_LOAD = 32'(GATE_BASE - 1);
    localparam logic [31:0] GAP_LOAD = 32'(GAP_CYCLES - 1);

    // The longest gate (range 3) has to fit the 32-bit counter, and inverted thresholds would oscillate.
    if (((64'(GATE_BASE) << 3) >= 64'h1_0000_0000) || (GATE_BASE == 0) ||
        (GAP_CYCLES == 0) || (LO_THR > HI_THR)) begin : g_param_check
        $error("freq_meter_seq: invalid parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPEN,
        S_CLOSE,
        S_CALC,
        S_OUT,
        S_GAP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] cnt;
    logic [1:0]  range;
    logic [1:0]  cur_range;
    logic [31:0] res_cnt;
    logic [1:0]  res_range;
    logic        res_timeout;

    logic cnt_zero;
    logic done_hit;
    logic tmo_hit;

    assign cnt_zero = (cnt == '0);
    assign done_hit = (state == S_CALC) && i_calc_done;
    // A done pulse in the last CALC cycle takes precedence over the timeout.
    assign tmo_hit  = ((state == S_CLOSE) && i_gate_real && cnt_zero) ||
                      ((state == S_CALC) && !i_calc_done && cnt_zero);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_run) state_nxt = S_OPEN;
            S_OPEN:  if (cnt_zero) state_nxt = S_CLOSE;
            S_CLOSE: begin
                if (!i_gate_real) begin
                    state_nxt = S_CALC;
                end else if (cnt_zero) begin
                    state_nxt = S_OUT;
                end
            end
            S_CALC:  if (done_hit || tmo_hit) state_nxt = S_OUT;
            S_OUT:   if (i_res_ready) state_nxt = S_GAP;
            S_GAP:   if (cnt_zero) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // One down-counter serves the gate window, both wait timeouts and the inter-measurement gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            cur_range <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_run) begin
                        cur_range <= range;
                        cnt       <= (GATE_W << range) - 32'd1;
                    end
                end
                S_OPEN: begin
                    if (cnt_zero) cnt <= TMO_LOAD;
                    else          cnt <= cnt - 32'd1;
                end
                S_CLOSE: begin
                    if (!i_gate_real)   cnt <= TMO_LOAD;
                    else if (!cnt_zero) cnt <= cnt - 32'd1;
                end
                S_OUT: begin
                    if (i_res_ready) cnt <= GAP_LOAD;
                end
                default: begin
                    if (!cnt_zero) cnt <= cnt - 32'd1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_cnt     <= '0;
            res_range   <= '0;
            res_timeout <= 1'b0;
        end else if (done_hit) begin
            res_cnt     <= i_cnt_x;
            res_range   <= cur_range;
            res_timeout <= 1'b0;
        end else if (tmo_hit) begin
            res_cnt     <= '0;
            res_range   <= cur_range;
            res_timeout <= 1'b1;
        end
    end

    // The key always wins; auto-ranging only nudges the range on a good result.
    always_ff @(posedge clk) begin
        if (rst) begin
            range <= '0;
        end else if (i_key_range) begin
            range <= range + 2'd1;
`ifdef FREQ_SEQ_AUTORANGE_EN
        end else if (done_hit) begin
            if ((i_cnt_x < LO_THR) && (range != 2'd3)) begin
                range <= range + 2'd1;
            end else if ((i_cnt_x > HI_THR) && (range != 2'd0)) begin
                range <= range - 2'd1;
            end
`endif
        end
    end

    assign o_gate_soft   = (state == S_OPEN);
    assign o_res_valid   = (state == S_OUT);
    assign o_busy        = (state != S_IDLE);
    assign o_range       = range;
    assign o_res_cnt     = res_cnt;
    assign o_res_range   = res_range;
    assign o_res_timeout = res_timeout;

endmodule

// File: tb/tb_freq_meter_seq.sv
// tb_freq_meter_seq: table-driven bench for freq_meter_seq with a small datapath stand-in and result scoreboard.
// Follows FREQ_SEQ_AUTORANGE_EN to pick the expected range sequence.
module tb_freq_meter_seq;

    localparam int unsigned GATE_BASE  = 240;
    localparam int unsigned GAP_CYCLES = 40;
    localparam int unsigned LO_THR     = 1000;
    localparam int unsigned HI_THR     = 100_000_000;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_run;
    logic        i_key_range;
    logic        o_gate_soft;
    logic        i_gate_real;
    logic        i_calc_done;
    logic [31:0] i_cnt_x;
    logic [1:0]  o_range;
    logic        o_res_valid;
    logic        i_res_ready;
    logic [31:0] o_res_cnt;
    logic [1:0]  o_res_range;
    logic        o_res_timeout;
    logic        o_busy;

    freq_meter_seq #(
        .GATE_BASE (GATE_BASE),
        .GAP_CYCLES(GAP_CYCLES),
        .LO_THR    (LO_THR),
        .HI_THR    (HI_THR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_run        (i_run),
        .i_key_range  (i_key_range),
        .o_gate_soft  (o_gate_soft),
        .i_gate_real  (i_gate_real),
        .i_calc_done  (i_calc_done),
        .i_cnt_x      (i_cnt_x),
        .o_range      (o_range),
        .o_res_valid  (o_res_valid),
        .i_res_ready  (i_res_ready),
        .o_res_cnt    (o_res_cnt),
        .o_res_range  (o_res_range),
        .o_res_timeout(o_res_timeout),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] cnt;
        int          dly;
        bit          hang;
        bit          stray;
        bit          key_mid;
        bit          key_done;
        bit          drop_run;
        int          hold;
        bit          gap_chk;
        int          exp_len;
        logic [31:0] exp_cnt;
        logic [1:0]  exp_rr;
        bit          exp_to;
        logic [1:0]  exp_range;
    } vec_t;

    typedef struct {
        logic [31:0] cnt;
        logic [1:0]  rr;
        bit          to;
    } res_t;

    res_t        sb[$];
    int          vecs = 0;
    int          miss = 0;
    int unsigned hs_edge = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] cnt, input int dly, input bit hang, input bit stray,
                                input bit key_mid, input bit key_done, input bit drop_run, input int hold,
                                input bit gap_chk, input int exp_len, input logic [31:0] exp_cnt,
                                input logic [1:0] exp_rr, input bit exp_to, input logic [1:0] exp_range);
        vec_t v;
        v.cnt = cnt;           v.dly = dly;         v.hang = hang;         v.stray = stray;
        v.key_mid = key_mid;   v.key_done = key_done; v.drop_run = drop_run; v.hold = hold;
        v.gap_chk = gap_chk;   v.exp_len = exp_len; v.exp_cnt = exp_cnt;   v.exp_rr = exp_rr;
        v.exp_to = exp_to;     v.exp_range = exp_range;
        return v;
    endfunction

    // Plays the datapath for one measurement: follows the soft gate, releases the real gate,
    // pulses done (or stalls), then accepts the result with optional backpressure.
    task automatic applyStimulus(input vec_t v, input string tag);
        int   n;
        int   len;
        int   ok;
        res_t e;
        e.cnt = v.exp_cnt;
        e.rr  = v.exp_rr;
        e.to  = v.exp_to;

        n = 0;
        while (o_gate_soft !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " gate_rise"}, 32'(o_gate_soft), 32'd1);
        if (v.gap_chk) checkOutput({tag, " gap_edges"}, cyc - hs_edge, GAP_CYCLES + 1);
        i_gate_real = 1'b1;

        len = 0;
        while (o_gate_soft === 1'b1 && len < 4000) begin
            len++;
            if (v.key_mid) i_key_range = (len == 10);
            if (v.drop_run && len == 10) i_run = 1'b0;
            if (v.stray) begin
                i_calc_done = (len == 20);
                i_cnt_x     = 32'd999;
            end
            @(negedge clk);
        end
        i_key_range = 1'b0;
        i_calc_done = 1'b0;
        checkOutput({tag, " gate_len"}, 32'(len), 32'(v.exp_len));

        if (v.hang) begin
            sb.push_back(e);
            n = 0;
            while (o_res_valid !== 1'b1 && n < 600) begin
                n++;
                @(negedge clk);
            end
            checkOutput({tag, " close_timeout_cycles"}, 32'(n), GATE_BASE);
        end else begin
            repeat (4) @(negedge clk);
            i_gate_real = 1'b0;
            if (v.dly == 0) begin
                sb.push_back(e);
                n = 0;
                while (o_res_valid !== 1'b1 && n < 600) begin
                    @(negedge clk);
                    n++;
                end
                // Includes the one CLOSE->CALC transition cycle.
                checkOutput({tag, " calc_timeout_cycles"}, 32'(n), GATE_BASE + 1);
            end else begin
                repeat (v.dly) @(negedge clk);
                i_calc_done = 1'b1;
                i_cnt_x     = v.cnt;
                i_key_range = v.key_done;
                sb.push_back(e);
                @(negedge clk);
                i_calc_done = 1'b0;
                i_key_range = 1'b0;
                i_cnt_x     = $urandom;
                checkOutput({tag, " valid_latency"}, 32'(o_res_valid), 32'd1);
            end
        end

        if (sb.size() > 0) e = sb.pop_front();
        checkOutput({tag, " res_cnt"}, o_res_cnt, e.cnt);
        checkOutput({tag, " res_range"}, 32'(o_res_range), 32'(e.rr));
        checkOutput({tag, " res_timeout"}, 32'(o_res_timeout), 32'(e.to));
        checkOutput({tag, " range_after"}, 32'(o_range), 32'(v.exp_range));

        i_res_ready = 1'b0;
        ok = 0;
        for (int k = 0; k < v.hold; k++) begin
            @(negedge clk);
            if (o_res_valid === 1'b1 && o_res_cnt === e.cnt && o_res_range === e.rr &&
                o_res_timeout === e.to && o_gate_soft === 1'b0) ok++;
        end
        if (v.hold > 0) checkOutput({tag, " hold_stable_cycles"}, 32'(ok), 32'(v.hold));

        i_res_ready = 1'b1;
        hs_edge     = cyc + 1;
        @(negedge clk);
        i_res_ready = 1'b0;
        checkOutput({tag, " valid_drop"}, 32'(o_res_valid), 32'd0);

        if (v.drop_run) begin
            n = 0;
            repeat (GAP_CYCLES + 20) begin
                @(negedge clk);
                if (o_gate_soft === 1'b1) n++;
            end
            checkOutput({tag, " parked_gates"}, 32'(n), 32'd0);
            checkOutput({tag, " parked_busy"}, 32'(o_busy), 32'd0);
        end
    endtask

    vec_t main_tab[6];
    vec_t tail_tab[$];

    initial begin
        //                cnt           dly  hng str kmd kdn drp hold gap len   ecnt        rr to rng
        main_tab[0] = mk(32'd1234,      3,   0,  1,  0,  0,  0,  0,   0,  240,  32'd1234,   0, 0, 0);
        main_tab[1] = mk(32'd5000,      3,   0,  0,  1,  0,  0,  100, 1,  240,  32'd5000,   0, 0, 1);
        main_tab[2] = mk(32'd77777,     240, 0,  0,  0,  0,  0,  0,   1,  480,  32'd77777,  1, 0, 1);
        main_tab[3] = mk(32'd55,        3,   1,  0,  0,  0,  0,  0,   1,  480,  32'd0,      1, 1, 1);
        main_tab[4] = mk(32'hDEADBEEF,  0,   0,  0,  0,  0,  0,  0,   1,  480,  32'd0,      1, 1, 1);
        main_tab[5] = mk(32'd2222,      3,   0,  0,  0,  0,  1,  0,   1,  480,  32'd2222,   1, 0, 1);

        tail_tab.push_back(mk(32'd4321,        3, 0, 0, 0, 0, 0, 0, 0, 480,  32'd4321,        1, 0, 1));
`ifdef FREQ_SEQ_AUTORANGE_EN
        tail_tab.push_back(mk(32'd200_000_000, 3, 0, 0, 0, 0, 0, 0, 1, 480,  32'd200_000_000, 1, 0, 0));
        tail_tab.push_back(mk(32'd10,          3, 0, 0, 0, 0, 0, 0, 1, 240,  32'd10,          0, 0, 1));
        tail_tab.push_back(mk(32'd10,          3, 0, 0, 0, 0, 0, 0, 1, 480,  32'd10,          1, 0, 2));
        tail_tab.push_back(mk(32'd200_000_000, 3, 0, 0, 0, 0, 0, 0, 1, 960,  32'd200_000_000, 2, 0, 1));
        tail_tab.push_back(mk(32'd200_000_000, 3, 0, 0, 0, 1, 0, 0, 1, 480,  32'd200_000_000, 1, 0, 2));
        tail_tab.push_back(mk(32'd10,          3, 0, 0, 0, 0, 0, 0, 1, 960,  32'd10,          2, 0, 3));
        tail_tab.push_back(mk(32'd10,          3, 0, 0, 0, 0, 0, 0, 1, 1920, 32'd10,          3, 0, 3));
        tail_tab.push_back(mk(32'd100_000_000, 3, 0, 0, 0, 0, 0, 0, 1, 1920, 32'd100_000_000, 3, 0, 3));
        tail_tab.push_back(mk(32'd100_000_001, 3, 0, 0, 0, 0, 0, 0, 1, 1920, 32'd100_000_001, 3, 0, 2));
`else
        tail_tab.push_back(mk(32'd10,          3, 0, 0, 0, 0, 0, 0, 1, 480,  32'd10,          1, 0, 1));
        tail_tab.push_back(mk(32'd200_000_000, 3, 0, 0, 0, 0, 0, 0, 1, 480,  32'd200_000_000, 1, 0, 1));
        tail_tab.push_back(mk(32'd200_000_000, 3, 0, 0, 0, 1, 0, 0, 1, 480,  32'd200_000_000, 1, 0, 2));
        tail_tab.push_back(mk(32'd10,          3, 0, 0, 0, 0, 0, 0, 1, 960,  32'd10,          2, 0, 2));
`endif

        rst         = 1'b1;
        i_run       = 1'b0;
        i_key_range = 1'b0;
        i_gate_real = 1'b0;
        i_calc_done = 1'b0;
        i_cnt_x     = '0;
        i_res_ready = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("reset gate_soft", 32'(o_gate_soft), 32'd0);
        checkOutput("reset res_valid", 32'(o_res_valid), 32'd0);
        checkOutput("reset busy", 32'(o_busy), 32'd0);
        checkOutput("reset range", 32'(o_range), 32'd0);
        checkOutput("reset res_cnt", o_res_cnt, 32'd0);
        checkOutput("reset res_range", 32'(o_res_range), 32'd0);
        checkOutput("reset res_timeout", 32'(o_res_timeout), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        i_run = 1'b1;
        @(negedge clk);
        checkOutput("gate_rise_latency", 32'(o_gate_soft), 32'd1);

        for (int i = 0; i < 6; i++) applyStimulus(main_tab[i], $sformatf("main%0d", i));

        // Reset in the middle of a gate window.
        i_run = 1'b1;
        for (int n = 0; n < 200 && o_gate_soft !== 1'b1; n++) @(negedge clk);
        repeat (10) @(negedge clk);
        checkOutput("pre_reset gate_soft", 32'(o_gate_soft), 32'd1);
        rst   = 1'b1;
        i_run = 1'b0;
        @(negedge clk);
        checkOutput("midopen_reset gate_soft", 32'(o_gate_soft), 32'd0);
        checkOutput("midopen_reset busy", 32'(o_busy), 32'd0);
        checkOutput("midopen_reset range", 32'(o_range), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Five key presses while parked wrap the range 0->1->2->3->0->1.
        for (int i = 0; i < 5; i++) begin
            i_key_range = 1'b1;
            @(negedge clk);
            i_key_range = 1'b0;
            checkOutput($sformatf("idle_key%0d range", i), 32'(o_range), 32'((i + 1) % 4));
            @(negedge clk);
        end

        i_run = 1'b1;
        foreach (tail_tab[i]) applyStimulus(tail_tab[i], $sformatf("tail%0d", i));

        i_run = 1'b0;
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
